// File: rtl/pifo_port_arbiter.sv
// rtl/pifo_port_arbiter.sv - round-robin arbiter sharing the PIFO tree array push/pop port
// Tracks per-tree occupancy, answers pops to empty trees locally, returns pop results in issue order.
module pifo_port_arbiter #(
    parameter int PTW      = 16,
    parameter int MTW      = 0,
    parameter int CTW      = 10,
    parameter int TREE_NUM = 4,
    parameter int N_REQ    = 4,
    parameter int POP_LAT  = 2,
    localparam int EW            = MTW + PTW,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int RID_BITS      = $clog2(N_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [N_REQ-1:0]               i_req_valid,
    input  logic [N_REQ-1:0]               i_req_pop,
    input  logic [N_REQ*TREE_NUM_BITS-1:0] i_req_tree_id,
    input  logic [N_REQ*EW-1:0]            i_req_data,
    output logic [N_REQ-1:0]               o_req_ready,
    output logic [TREE_NUM_BITS-1:0]       o_tree_id,
    output logic                           o_push,
    output logic [EW-1:0]                  o_push_data,
    output logic                           o_pop,
    input  logic                           i_task_fail,
    input  logic [EW-1:0]                  i_pop_data,
    output logic                           o_rsp_valid,
    output logic [RID_BITS-1:0]            o_rsp_id,
    output logic [EW-1:0]                  o_rsp_data,
    output logic                           o_rsp_empty,
    output logic [15:0]                    o_fail_cnt
);

    logic [RID_BITS-1:0]      rr_ptr;
    logic [RID_BITS-1:0]      win_id;
    logic                     win_found;
    logic [RID_BITS:0]        scan_sum;
    logic [RID_BITS-1:0]      scan_idx;
    logic                     win_pop;
    logic [TREE_NUM_BITS-1:0] win_tree;
    logic [EW-1:0]            win_data;
    logic [CTW-1:0]           win_cnt;
    logic                     is_local;
    logic                     is_blocked;
    logic                     is_fwd;
    logic                     accept;
    logic                     reject;
    logic [CTW-1:0]           occ [TREE_NUM];

    logic                     pipe_valid [POP_LAT];
    logic [RID_BITS-1:0]      pipe_rid   [POP_LAT];
    logic                     pipe_local [POP_LAT];

    // Round-robin scan starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (RID_BITS+1)'(i);
            if (scan_sum >= (RID_BITS+1)'(N_REQ))
                scan_sum = scan_sum - (RID_BITS+1)'(N_REQ);
            scan_idx = scan_sum[RID_BITS-1:0];
            if (!win_found && i_req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    always_comb begin
        win_pop  = 1'b0;
        win_tree = '0;
        win_data = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (win_id == RID_BITS'(r)) begin
                win_pop  = i_req_pop[r];
                win_tree = i_req_tree_id[r*TREE_NUM_BITS +: TREE_NUM_BITS];
                win_data = i_req_data[r*EW +: EW];
            end
        end
    end

    assign win_cnt    = occ[win_tree];
    assign is_local   = win_found && win_pop && (win_cnt == '0);
    assign is_blocked = win_found && !win_pop && (win_cnt == '1);
    assign is_fwd     = win_found && !is_local && !is_blocked;
    assign accept     = is_local || (is_fwd && !i_task_fail);
    assign reject     = win_found && !accept;

    always_comb begin
        o_req_ready = '0;
        o_tree_id   = '0;
        o_push      = 1'b0;
        o_push_data = '0;
        o_pop       = 1'b0;
        if (!i_rst) begin
            if (accept)
                o_req_ready[win_id] = 1'b1;
            if (is_fwd) begin
                o_tree_id   = win_tree;
                o_push      = !win_pop;
                o_pop       = win_pop;
                o_push_data = win_pop ? '0 : win_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr     <= '0;
            o_fail_cnt <= '0;
            for (int t = 0; t < TREE_NUM; t++)
                occ[t] <= '0;
        end else begin
            if (win_found)
                rr_ptr <= (win_id == RID_BITS'(N_REQ-1)) ? '0 : win_id + RID_BITS'(1);
            if (reject && o_fail_cnt != 16'hFFFF)
                o_fail_cnt <= o_fail_cnt + 16'd1;
            // Counter tracks accepted pushes minus accepted forwarded pops, never corrected by empty returns.
            if (accept && is_fwd)
                occ[win_tree] <= win_pop ? win_cnt - CTW'(1) : win_cnt + CTW'(1);
        end
    end

    // Local pops ride the same delay line so responses leave in issue order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < POP_LAT; k++) begin
                pipe_valid[k] <= 1'b0;
                pipe_rid[k]   <= '0;
                pipe_local[k] <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= accept && win_pop;
            pipe_rid[0]   <= (accept && win_pop) ? win_id : '0;
            pipe_local[0] <= is_local;
            for (int k = 1; k < POP_LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_rid[k]   <= pipe_rid[k-1];
                pipe_local[k] <= pipe_local[k-1];
            end
        end
    end

    always_comb begin
        o_rsp_valid = 1'b0;
        o_rsp_id    = '0;
        o_rsp_data  = '0;
        o_rsp_empty = 1'b0;
        if (!i_rst) begin
            o_rsp_valid = pipe_valid[POP_LAT-1];
            o_rsp_id    = pipe_rid[POP_LAT-1];
            o_rsp_data  = pipe_local[POP_LAT-1] ? '1 : i_pop_data;
            o_rsp_empty = pipe_local[POP_LAT-1] || (i_pop_data == '1);
        end
    end

endmodule

// File: tb/tb_pifo_port_arbiter.sv
// tb/tb_pifo_port_arbiter.sv - directed and random checks of pifo_port_arbiter against a queue-based model
module tb_pifo_port_arbiter;
    localparam int PTW = 16, MTW = 0, CTW = 10, TREE_NUM = 4, N_REQ = 4, POP_LAT = 2;
    localparam int EW = MTW + PTW, TB = 2, RB = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid, req_pop, req_ready;
    logic [N_REQ*TB-1:0] req_tree;
    logic [N_REQ*EW-1:0] req_data;
    logic [TB-1:0]       tree_id;
    logic                push, pop, task_fail, rsp_valid, rsp_empty;
    logic [EW-1:0]       push_data, pop_data, rsp_data;
    logic [RB-1:0]       rsp_id;
    logic [15:0]         fail_cnt;

    always #5 clk = ~clk;

    pifo_port_arbiter #(.PTW(PTW), .MTW(MTW), .CTW(CTW), .TREE_NUM(TREE_NUM),
                        .N_REQ(N_REQ), .POP_LAT(POP_LAT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_pop(req_pop), .i_req_tree_id(req_tree),
        .i_req_data(req_data), .o_req_ready(req_ready),
        .o_tree_id(tree_id), .o_push(push), .o_push_data(push_data), .o_pop(pop),
        .i_task_fail(task_fail), .i_pop_data(pop_data),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
        .o_rsp_empty(rsp_empty), .o_fail_cnt(fail_cnt)
    );

    typedef struct {
        int            due;
        int            rid;
        bit            loc;
        logic [EW-1:0] data;
    } rsp_t;

    int            n_vec = 0, n_err = 0, cyc = 0;
    int            m_rr, m_fail;
    int            m_occ [TREE_NUM];
    logic [EW-1:0] tq [TREE_NUM][$];
    rsp_t          sb [$];
    int            w, m_tree;
    bit            m_pop, e_loc, e_fwd, e_acc;
    logic [EW-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_pop = '0; req_tree = '0; req_data = '0; task_fail = 1'b0;
    endtask

    task automatic set_req(input int r, input bit p, input int tree, input logic [EW-1:0] d);
        req_valid[r]         = 1'b1;
        req_pop[r]           = p;
        req_tree[r*TB +: TB] = TB'(tree);
        req_data[r*EW +: EW] = d;
    endtask

    // Predict this cycle from the model, drive the array's pop data, then sample.
    task automatic eval();
        bit have_rsp;
        int r;
        w = -1;
        for (int i = 0; i < N_REQ; i++) begin
            r = (m_rr + i) % N_REQ;
            if (w < 0 && req_valid[r]) w = r;
        end
        m_pop = 0; m_tree = 0; m_data = '0; e_loc = 0; e_fwd = 0; e_acc = 0;
        if (w >= 0) begin
            m_pop  = req_pop[w];
            m_tree = int'(req_tree[w*TB +: TB]);
            m_data = req_data[w*EW +: EW];
            e_loc  = m_pop && m_occ[m_tree] == 0;
            e_fwd  = !e_loc && !(!m_pop && m_occ[m_tree] == (1 << CTW) - 1);
            e_acc  = e_loc || (e_fwd && !task_fail);
        end
        have_rsp = sb.size() > 0 && sb[0].due == cyc;
        pop_data = (have_rsp && !sb[0].loc) ? sb[0].data : EW'($urandom_range(0, 16'hFFFE));
        #1;
        chk("ready", req_ready, (!rst && w >= 0 && e_acc) ? (1 << w) : 0);
        chk("push", push, !rst && e_fwd && !m_pop);
        chk("pop", pop, !rst && e_fwd && m_pop);
        chk("tree_id", tree_id, (!rst && e_fwd) ? m_tree : 0);
        chk("push_data", push_data, (!rst && e_fwd && !m_pop) ? m_data : 0);
        chk("rsp_valid", rsp_valid, !rst && have_rsp);
        if (!rst && have_rsp) begin
            chk("rsp_id", rsp_id, sb[0].rid);
            chk("rsp_data", rsp_data, sb[0].loc ? 16'hFFFF : sb[0].data);
            chk("rsp_empty", rsp_empty, sb[0].loc);
        end
        if (!rst) chk("fail_cnt", fail_cnt, m_fail);
    endtask

    task automatic advance();
        rsp_t e;
        if (rst) begin
            m_rr = 0; m_fail = 0;
            for (int t = 0; t < TREE_NUM; t++) begin
                m_occ[t] = 0;
                tq[t].delete();
            end
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) void'(sb.pop_front());
            if (w >= 0) begin
                m_rr = (w + 1) % N_REQ;
                if (!e_acc && m_fail < 65535) m_fail++;
                if (e_acc && e_fwd && !m_pop) begin
                    m_occ[m_tree]++;
                    tq[m_tree].push_back(m_data);
                end
                if (e_acc && m_pop) begin
                    e.due = cyc + POP_LAT; e.rid = w; e.loc = e_loc; e.data = '1;
                    if (e_fwd) begin
                        m_occ[m_tree]--;
                        e.data = tq[m_tree].pop_front();
                    end
                    sb.push_back(e);
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        advance();
    endtask

    task automatic do_reset();
        clear_reqs(); rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        clear_reqs();
        rst = 1'b1;
        m_rr = 0; m_fail = 0;
        for (int t = 0; t < TREE_NUM; t++) m_occ[t] = 0;
        @(negedge clk);
        set_req(0, 0, 1, 16'h1234);
        eval(); chk("rst_ready", req_ready, 0); chk("rst_push", push, 0); advance();
        rst = 1'b0;

        clear_reqs(); set_req(1, 0, 2, 16'h00AB);
        eval();
        chk("tp_push_ready", req_ready, 4'b0010); chk("tp_push", push, 1);
        chk("tp_tree", tree_id, 2); chk("tp_pdata", push_data, 16'h00AB);
        advance();
        clear_reqs(); set_req(3, 1, 2, '0);
        eval(); chk("tp_pop", pop, 1); advance();
        clear_reqs(); step();
        eval();
        chk("tp_rsp_v", rsp_valid, 1); chk("tp_rsp_id", rsp_id, 3);
        chk("tp_rsp_d", rsp_data, 16'h00AB); chk("tp_rsp_e", rsp_empty, 0);
        advance();

        set_req(0, 1, 1, '0);
        eval(); chk("lp_pop", pop, 0); chk("lp_ready", req_ready, 4'b0001); advance();
        clear_reqs(); step();
        eval();
        chk("lp_rsp_v", rsp_valid, 1); chk("lp_rsp_id", rsp_id, 0);
        chk("lp_rsp_d", rsp_data, 16'hFFFF); chk("lp_rsp_e", rsp_empty, 1);
        advance();

        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < N_REQ; r++) set_req(r, 0, 0, EW'(16 * k + r));
            eval(); chk("rr_grant", req_ready, 1 << (k % 4)); advance();
        end
        clear_reqs();
        for (int k = 0; k < 9; k++) begin
            set_req(1, 1, 0, '0);
            eval(); chk("occ8_fwd", pop, k < 8); advance();
        end

        clear_reqs();
        for (int k = 0; k < 6; k++) begin
            set_req(2, 0, 1, EW'(k)); set_req(3, 0, 1, EW'(16'h100 + k));
            task_fail = (k % 2 == 0);
            eval(); chk("fail_alt", req_ready, (k % 2 == 0) ? 0 : 4'b1000); advance();
        end
        clear_reqs();
        eval(); chk("fail_cnt3", fail_cnt, 3); advance();
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1, 1, '0);
            eval(); chk("occ3_fwd", pop, k < 3); advance();
        end
        clear_reqs(); step(); step();

        do_reset();
        for (int k = 0; k < (1 << CTW) - 1; k++) begin
            set_req(0, 0, 3, EW'($urandom_range(0, 16'hFFFE)));
            step();
        end
        set_req(0, 0, 3, 16'h5555);
        eval(); chk("sat_ready", req_ready, 0); chk("sat_push", push, 0); advance();
        clear_reqs();
        eval(); chk("sat_fail", fail_cnt, 1); advance();

        do_reset();
        set_req(0, 0, 2, 16'h0011); step();
        set_req(0, 0, 2, 16'h0022); step();
        clear_reqs(); set_req(1, 1, 2, '0); step(); step();
        clear_reqs(); rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            eval(); chk("flush_rsp", rsp_valid, 0); advance();
        end
        for (int r = 0; r < N_REQ; r++) set_req(r, 0, 0, 16'h0042);
        eval(); chk("rst_rr", req_ready, 4'b0001); advance();
        clear_reqs(); set_req(0, 1, 2, '0);
        eval(); chk("rst_occ", pop, 0); advance();

        for (int n = 0; n < 400; n++) begin
            clear_reqs();
            for (int r = 0; r < N_REQ; r++)
                if ($urandom % 3 != 0)
                    set_req(r, bit'($urandom % 2), int'($urandom % TREE_NUM),
                            EW'($urandom_range(0, 16'hFFFE)));
            task_fail = ($urandom % 5 == 0);
            rst = ($urandom % 100 == 0);
            step();
        end
        rst = 1'b0; clear_reqs();
        for (int k = 0; k < POP_LAT + 1; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
